lut_cascade_prog: RTL and testbench

Runtime-programmable two-stage 4-input LUT cascade: LUT A evaluates I[3:0], and LUT B evaluates {A, I[6:4]}. Both truth tables (INIT words) are written through a byte-wide valid/ready configuration port. A new pair is committed atomically, so evaluation always uses one consistent pair. This is the configuration-writer counterpart of the fixed cascade test designs: the bench can reprogram the cascade and read both stage outputs without resynthesis.

---
 rtl/lut_cascade_pkg.sv | 17 +
 rtl/lut4_eval.sv | 11 +
 rtl/lut_cascade_prog.sv | 151 +++++++++++++++
 tb/tb_lut_cascade_prog.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_cascade_pkg.sv
// Shared types and constants for the programmable two-stage LUT cascade.
// Holds the config FSM encoding, load length and power-on truth tables.
package lut_cascade_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_t;

  localparam int unsigned CFG_BYTES = 4;
  localparam int unsigned CNT_W     = $clog2(CFG_BYTES);

  localparam logic [15:0] INIT_A_DEF = 16'hD701;
  localparam logic [15:0] INIT_B_DEF = 16'hD601;

endpackage

// File: rtl/lut4_eval.sv
// Combinational 4-input LUT: bit n of the truth table is the output for index n.
// No state and no handshake.
module lut4_eval (
  input  logic [15:0] init_i,
  input  logic [3:0]  idx_i,
  output logic        out_o
);

  assign out_o = init_i[idx_i];

endmodule

// File: rtl/lut_cascade_prog.sv
// Two-stage LUT cascade (A on I[3:0], B on {A, I[6:4]}) with a byte-wide config port.
// I->O latency 1 cycle (PIPE=0) or 2 (PIPE=1); evaluation never stalls, config stalls only in COMMIT.
module lut_cascade_prog
  import lut_cascade_pkg::*;
#(
  parameter logic [15:0] INIT_A = INIT_A_DEF,
  parameter logic [15:0] INIT_B = INIT_B_DEF,
  parameter int unsigned PIPE   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  input  logic       cfg_abort,
  output logic       cfg_done,
  input  logic       in_valid,
  input  logic [6:0] I,
  output logic       out_valid,
  output logic [1:0] O
);

  cfg_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      shadow_q;
  logic [15:0]      act_a_q;
  logic [15:0]      act_b_q;
  logic             ready_q;
  logic             done_q;

  // Abort wins over a simultaneous byte, so the handshake is withheld that cycle.
  assign cfg_ready = ready_q & ~cfg_abort;
  assign cfg_done  = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      act_a_q  <= INIT_A;
      act_b_q  <= INIT_B;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          if (cfg_abort) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cfg_valid) begin
            shadow_q[{cnt_q, 3'b000} +: 8] <= cfg_data;
            if (cnt_q == CNT_W'(CFG_BYTES - 1)) begin
              state_q <= COMMIT;
              cnt_q   <= '0;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= LOAD;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          act_a_q <= shadow_q[15:0];
          act_b_q <= shadow_q[31:16];
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  logic        a_w;
  logic        b_w;
  logic        s1_a;
  logic        s1_vld;
  logic [2:0]  s1_hi;
  logic [15:0] s1_initb;

  lut4_eval u_lut_a (
    .init_i (act_a_q),
    .idx_i  (I[3:0]),
    .out_o  (a_w)
  );

  generate
    if (PIPE != 0) begin : g_pipe
      logic        a_q;
      logic        vld_q;
      logic [2:0]  hi_q;
      logic [15:0] initb_q;

      // B's table travels with the sample so a commit cannot split one evaluation.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q     <= 1'b0;
          vld_q   <= 1'b0;
          hi_q    <= '0;
          initb_q <= '0;
        end else begin
          vld_q <= in_valid;
          if (in_valid) begin
            a_q     <= a_w;
            hi_q    <= I[6:4];
            initb_q <= act_b_q;
          end
        end
      end

      assign s1_a     = a_q;
      assign s1_vld   = vld_q;
      assign s1_hi    = hi_q;
      assign s1_initb = initb_q;
    end else begin : g_comb
      assign s1_a     = a_w;
      assign s1_vld   = in_valid;
      assign s1_hi    = I[6:4];
      assign s1_initb = act_b_q;
    end
  endgenerate

  lut4_eval u_lut_b (
    .init_i (s1_initb),
    .idx_i  ({s1_a, s1_hi}),
    .out_o  (b_w)
  );

  logic       out_vld_q;
  logic [1:0] o_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      o_q       <= 2'b00;
    end else begin
      out_vld_q <= s1_vld;
      if (s1_vld) begin
        o_q <= {b_w, s1_a};
      end
    end
  end

  assign out_valid = out_vld_q;
  assign O         = o_q;

endmodule

// File: tb/tb_lut_cascade_prog.sv
// Directed bench for lut_cascade_prog: a PIPE=0 and a PIPE=1 instance share all inputs.
module tb_lut_cascade_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_abort = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [6:0] I = 7'h00;

  logic       rdy0, done0, ov0;
  logic       rdy1, done1, ov1;
  logic [1:0] o0, o1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lut_cascade_prog #(.PIPE(0)) u0 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy0), .cfg_data(cfg_data),
    .cfg_abort(cfg_abort), .cfg_done(done0), .in_valid(in_valid), .I(I),
    .out_valid(ov0), .O(o0)
  );

  lut_cascade_prog #(.PIPE(1)) u1 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(rdy1), .cfg_data(cfg_data),
    .cfg_abort(cfg_abort), .cfg_done(done1), .in_valid(in_valid), .I(I),
    .out_valid(ov1), .O(o1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_o(input logic [15:0] ta, input logic [15:0] tb,
                                       input logic [6:0] x);
    logic a;
    logic [3:0] bi;
    a  = ta[x[3:0]];
    bi = {a, x[6:4]};
    return {tb[bi], a};
  endfunction

  task automatic load4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int n = 0; n < 4; n++) begin
      cfg_valid = 1'b1;
      cfg_data  = bytes[n];
      step();
    end
    cfg_data = 8'hEE;
    chk("load_commit_rdy", 32'(rdy0), 32'd0);
    chk("load_commit_done", 32'(done0), 32'd1);
    chk("load_commit_done_p1", 32'(done1), 32'd1);
    step();
    cfg_valid = 1'b0;
    chk("load_after_rdy", 32'(rdy0), 32'd1);
    chk("load_after_done", 32'(done0), 32'd0);
  endtask

  initial begin
    logic [1:0] prev_exp;
    logic [1:0] e0;
    logic [1:0] e1;

    // Reset state
    step();
    step();
    chk("rst_rdy", 32'(rdy0), 32'd0);
    chk("rst_rdy_p1", 32'(rdy1), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ov", 32'(ov0), 32'd0);
    chk("rst_o", 32'(o0), 32'd0);
    chk("rst_ov_p1", 32'(ov1), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_rdy", 32'(rdy0), 32'd1);

    // Default tables: spot checks then full sweep
    in_valid = 1'b1;
    I = 7'h08;
    step();
    chk("def_08", 32'(o0), 32'b01);
    chk("def_08_ov", 32'(ov0), 32'd1);
    I = 7'h18;
    step();
    chk("def_18", 32'(o0), 32'b11);
    chk("def_08_p1", 32'(o1), 32'b01);
    prev_exp = 2'b11;
    for (int k = 0; k < 128; k++) begin
      I = 7'(k);
      step();
      chk("sweep_p0", 32'(o0), 32'(ref_o(16'hD701, 16'hD601, 7'(k))));
      chk("sweep_p1", 32'(o1), 32'(prev_exp));
      prev_exp = ref_o(16'hD701, 16'hD601, 7'(k));
    end

    // A=FFFF, B=0000 -> every I gives 01
    load4(8'hFF, 8'hFF, 8'h00, 8'h00);
    I = 7'h00;
    step();
    chk("ff00_00", 32'(o0), 32'b01);
    I = 7'h7F;
    step();
    chk("ff00_7f", 32'(o0), 32'b01);
    I = 7'h35;
    step();
    chk("ff00_35", 32'(o0), 32'b01);

    // A=FFFE, B=0000: I=0 gives 00
    load4(8'hFE, 8'hFF, 8'h00, 8'h00);
    I = 7'h00;
    step();
    chk("fe_00", 32'(o0), 32'b00);
    I = 7'h01;
    step();
    chk("fe_01", 32'(o0), 32'b01);

    // Load A=0000, B=FFFF while streaming I=0
    I = 7'h00;
    for (int k = 0; k < 7; k++) begin
      cfg_valid = (k < 4);
      cfg_data  = (k < 2) ? 8'h00 : 8'hFF;
      step();
      chk("stream_commit_o", 32'(o0), (k <= 4) ? 32'b00 : 32'b10);
      chk("stream_commit_done", 32'(done0), (k == 3) ? 32'd1 : 32'd0);
    end
    cfg_valid = 1'b0;

    // Two bytes, then abort together with a byte
    cfg_valid = 1'b1;
    cfg_data = 8'h11;
    step();
    cfg_data = 8'h22;
    step();
    cfg_data  = 8'hAA;
    cfg_abort = 1'b1;
    #1;
    chk("abort_rdy", 32'(rdy0), 32'd0);
    step();
    chk("abort_done", 32'(done0), 32'd0);
    cfg_abort = 1'b0;
    cfg_data = 8'h00;
    step();
    chk("abort_b0_done", 32'(done0), 32'd0);
    cfg_data = 8'hFF;
    step();
    chk("abort_b1_done", 32'(done0), 32'd0);
    cfg_data = 8'h01;
    step();
    chk("abort_b2_done", 32'(done0), 32'd0);
    cfg_data = 8'h00;
    step();
    chk("abort_b3_done", 32'(done0), 32'd1);
    cfg_valid = 1'b0;
    step();
    // A=FF00 (A=I[3]), B=0001 (B=1 only at index 0)
    I = 7'h08;
    step();
    chk("ab_08", 32'(o0), 32'b01);
    I = 7'h00;
    step();
    chk("ab_00", 32'(o0), 32'b10);
    I = 7'h10;
    step();
    chk("ab_10", 32'(o0), 32'b00);
    I = 7'h07;
    step();
    chk("ab_07", 32'(o0), 32'b10);
    in_valid = 1'b0;
    I = 7'h08;
    step();
    chk("hold_ov", 32'(ov0), 32'd0);
    chk("hold_o", 32'(o0), 32'b10);

    // Reset after three bytes of a load
    cfg_valid = 1'b1;
    cfg_data = 8'h55;
    step();
    step();
    step();
    cfg_valid = 1'b0;
    in_valid = 1'b1;
    rst = 1'b1;
    step();
    chk("midrst_rdy", 32'(rdy0), 32'd0);
    chk("midrst_ov", 32'(ov0), 32'd0);
    chk("midrst_o", 32'(o0), 32'd0);
    chk("midrst_ov_p1", 32'(ov1), 32'd0);
    rst = 1'b0;
    I = 7'h08;
    step();
    chk("midrst_rdy_after", 32'(rdy0), 32'd1);
    chk("midrst_def_08", 32'(o0), 32'b01);
    I = 7'h18;
    step();
    chk("midrst_def_18", 32'(o0), 32'b11);
    load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    I = 7'h55;
    step();
    chk("all1_55", 32'(o0), 32'b11);

    // Commit A=0000,B=0000 while streaming I=0F into both pipelines
    in_valid = 1'b0;
    step();
    step();
    I = 7'h0F;
    for (int k = 0; k < 10; k++) begin
      in_valid  = (k < 8);
      cfg_valid = (k < 4);
      cfg_data  = 8'h00;
      step();
      e0 = (k <= 4) ? 2'b11 : 2'b00;
      e1 = (k - 1 <= 4) ? 2'b11 : 2'b00;
      if (k < 8) begin
        chk("pipe_p0_ov", 32'(ov0), 32'd1);
        chk("pipe_p0_o", 32'(o0), 32'(e0));
      end else begin
        chk("pipe_p0_ov_off", 32'(ov0), 32'd0);
        chk("pipe_p0_hold", 32'(o0), 32'b00);
      end
      if (k == 0 || k == 9) begin
        chk("pipe_p1_ov_off", 32'(ov1), 32'd0);
      end else begin
        chk("pipe_p1_ov", 32'(ov1), 32'd1);
      end
      chk("pipe_p1_o", 32'(o1), (k == 0) ? 32'b11 : ((k == 9) ? 32'b00 : 32'(e1)));
      if (k == 3) begin
        chk("pipe_done_p1", 32'(done1), 32'd1);
      end
    end
    cfg_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
